hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV32 core. It drives the two 3-input forwarding mux selects, the bubble control (`ctrlf`) of the ID/EX control-squash mux, and the per-stage write enables. It owns the load-use stall, the taken-branch flush and the multi-cycle data-memory wait freeze, including a wait watchdog.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/fwd_select.sv | 28 ++
 rtl/hazard_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline hazard controller.
//   fwd_sel_t  - forwarding mux select encoding (register file / EX-MEM / MEM-WB)
//   hz_state_t - memory-wait FSM states
//   TIMEOUT_DEF- default watchdog limit in MEMWAIT cycles
package hazard_pkg;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: forwarding select for one EX source operand.
//   ex_rs                     - source register of the instruction in EX
//   mem_rd / mem_regwrite     - EX/MEM writeback target
//   wb_rd  / wb_regwrite      - MEM/WB writeback target
//   sel                       - FWD_MEM beats FWD_WB beats FWD_REG; x0 never forwards
module fwd_select
    import hazard_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    output fwd_sel_t        sel
);

    always_comb begin
        sel = FWD_REG;
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
            sel = FWD_WB;
        // Younger result wins, so the EX/MEM test overrides the MEM/WB one.
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))
            sel = FWD_MEM;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RV32 pipeline.
//   Inputs : ID/EX/MEM/WB register addresses and write flags, mem_req,
//            dmem_ready, branch_taken, clk, reset (async, active high).
//   Outputs: fwd_a/fwd_b forwarding selects, pc/ifid/idex/exmem write enables,
//            ifid_flush, ctrlf (ID/EX control squash), memwb_bubble,
//            sticky mem_timeout watchdog flag.
//   Build option HAZARD_PERF_EN adds the stall_cycles / flush_count counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W    = 5,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_memread,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    input  logic            mem_req,
    input  logic            dmem_ready,
    input  logic            branch_taken,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            idex_we,
    output logic            exmem_we,
    output logic            ifid_flush,
    output logic            ctrlf,
    output logic            memwb_bubble,
    output logic            mem_timeout
`ifdef HAZARD_PERF_EN
   ,output logic [CNT_W-1:0] stall_cycles
   ,output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    hz_state_t       state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;
    fwd_sel_t        sel_a, sel_b;
    logic            freeze, loaduse;

    fwd_select #(.RA_W(RA_W)) u_fwd_a (
        .ex_rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_a)
    );

    fwd_select #(.RA_W(RA_W)) u_fwd_b (
        .ex_rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_b)
    );

    // The freeze drops in the very cycle dmem_ready is seen, so an access
    // with N wait cycles freezes for exactly N cycles and a zero-wait access
    // never freezes; MEMWAIT ignores mem_req while waiting.
    assign freeze  = !dmem_ready && ((state_q == MEMWAIT) || mem_req);
    assign loaduse = ex_memread && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Pipeline control, priority freeze > branch > load-use > none.
    always_comb begin
        fwd_a        = sel_a;
        fwd_b        = sel_b;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        ifid_flush   = 1'b0;
        ctrlf        = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            fwd_a        = FWD_REG;
            fwd_b        = FWD_REG;
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            ctrlf        = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            // Squashing ID also discards any load-use hit on it.
            ifid_flush   = 1'b1;
            ctrlf        = 1'b1;
        end else if (loaduse) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ctrlf        = 1'b1;
        end
    end

    // Memory-wait FSM and watchdog.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_req && !dmem_ready)
                    state_d = MEMWAIT;
            end
            MEMWAIT: begin
                // Saturate so a long hang cannot wrap the count.
                wait_cnt_d = (wait_cnt_q == WC_W'(TIMEOUT)) ? wait_cnt_q
                                                            : wait_cnt_q + WC_W'(1);
                if (wait_cnt_d == WC_W'(TIMEOUT))
                    mem_timeout_d = 1'b1;
                if (dmem_ready)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (freeze || loaduse)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (branch_taken && !freeze)
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
